// File: rtl/ft_bus_sched_if.sv
// FTDI-side strobes, selector/TX FIFO handshakes and scheduler outputs for ft_bus_sched.
// Word-count ports exist only when FT_SCHED_STATS_EN is defined.
interface ft_bus_sched_if;
  logic rxf_n_i;
  logic txe_n_i;
  logic sel_full_i;
  logic tx_empty_i;
  logic ft_oe_n_o;
  logic ft_rd_n_o;
  logic ft_wr_n_o;
  logic bus_dir_o;
  logic sel_we_o;
  logic tx_rd_o;
  logic busy_o;
`ifdef FT_SCHED_STATS_EN
  logic [31:0] rx_words_o;
  logic [31:0] tx_words_o;

  modport slave (
    input  rxf_n_i, txe_n_i, sel_full_i, tx_empty_i,
    output ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, bus_dir_o, sel_we_o, tx_rd_o, busy_o,
    output rx_words_o, tx_words_o
  );
  modport master (
    output rxf_n_i, txe_n_i, sel_full_i, tx_empty_i,
    input  ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, bus_dir_o, sel_we_o, tx_rd_o, busy_o,
    input  rx_words_o, tx_words_o
  );
`else
  modport slave (
    input  rxf_n_i, txe_n_i, sel_full_i, tx_empty_i,
    output ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, bus_dir_o, sel_we_o, tx_rd_o, busy_o
  );
  modport master (
    output rxf_n_i, txe_n_i, sel_full_i, tx_empty_i,
    input  ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, bus_dir_o, sel_we_o, tx_rd_o, busy_o
  );
`endif
endinterface

// File: rtl/ft_bus_sched.sv
// Half-duplex FTDI FIFO bus scheduler: alternating RX/TX grants, bounded bursts, turnaround gap.
// Define FT_SCHED_STATS_EN to add free-running RX/TX word counters.
module ft_bus_sched #(
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned CNT_W       = 9
) (
  input logic           clk_i,
  input logic           reset_n,
  ft_bus_sched_if.slave bus
);
  localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RX_OE, RX_BURST, TX_BURST, TURN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_cnt_nxt;
  logic              last_rx, last_rx_nxt;
  logic              oe_n, rd_n, dir, busy;
  logic              oe_n_nxt, rd_n_nxt, dir_nxt, busy_nxt;
  logic              rx_ok, tx_ok, burst_end;
  logic              sel_we, tx_rd;

  assign rx_ok     = ~bus.rxf_n_i & ~bus.sel_full_i;
  assign tx_ok     = ~bus.txe_n_i & ~bus.tx_empty_i;
  assign burst_end = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // Transfer strobes are gated by the live inputs so a dropped request blocks that cycle's word
  assign sel_we = (state == RX_BURST) & rx_ok;
  assign tx_rd  = (state == TX_BURST) & tx_ok;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      turn_cnt  <= '0;
      last_rx   <= 1'b0;
      oe_n      <= 1'b1;
      rd_n      <= 1'b1;
      dir       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      turn_cnt  <= turn_cnt_nxt;
      last_rx   <= last_rx_nxt;
      oe_n      <= oe_n_nxt;
      rd_n      <= rd_n_nxt;
      dir       <= dir_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    turn_cnt_nxt  = turn_cnt;
    last_rx_nxt   = last_rx;
    unique case (state)
      IDLE: begin
        turn_cnt_nxt = '0;
        // On a tie the direction not served last wins
        if (rx_ok && (!tx_ok || !last_rx)) begin
          state_nxt   = RX_OE;
          last_rx_nxt = 1'b1;
        end else if (tx_ok) begin
          state_nxt   = TX_BURST;
          last_rx_nxt = 1'b0;
        end
      end
      RX_OE: state_nxt = RX_BURST;
      RX_BURST: begin
        if (rx_ok) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (!rx_ok || burst_end) state_nxt = TURN;
      end
      TX_BURST: begin
        if (tx_ok) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (!tx_ok || burst_end) state_nxt = TURN;
      end
      TURN: begin
        burst_cnt_nxt = '0;
        if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
          state_nxt    = IDLE;
          turn_cnt_nxt = '0;
        end else begin
          turn_cnt_nxt = turn_cnt + TURN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    oe_n_nxt = ~((state_nxt == RX_OE) || (state_nxt == RX_BURST));
    rd_n_nxt = (state_nxt != RX_BURST);
    dir_nxt  = (state_nxt == TX_BURST);
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.ft_oe_n_o = oe_n;
  assign bus.ft_rd_n_o = rd_n;
  assign bus.bus_dir_o = dir;
  assign bus.busy_o    = busy;
  assign bus.ft_wr_n_o = ~tx_rd;
  assign bus.sel_we_o  = sel_we;
  assign bus.tx_rd_o   = tx_rd;

`ifdef FT_SCHED_STATS_EN
  logic [31:0] rx_words, tx_words;

  // Free-running word counters, wrap naturally at 2^32
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      rx_words <= '0;
      tx_words <= '0;
    end else begin
      if (sel_we) rx_words <= rx_words + 32'd1;
      if (tx_rd)  tx_words <= tx_words + 32'd1;
    end
  end

  assign bus.rx_words_o = rx_words;
  assign bus.tx_words_o = tx_words;
`endif
endmodule
